// File: rtl/tt_um_uart_rx.sv
// 8N1 UART receiver: 2-flop synced rx, byte and flags valid one cycle after the stop-sample edge.
// No backpressure: an unacknowledged byte is overwritten and flagged as overrun.
module tt_um_uart_rx #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   output logic [7:0] uo_out,
   input  logic [7:0] uio_in,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   localparam logic [15:0] HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);
   localparam logic [15:0] FULL_M1 = 16'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_WAIT_HIGH
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [15:0] r_cnt;
   logic [15:0] w_cnt_nxt;
   logic [2:0]  r_bit;
   logic [2:0]  w_bit_nxt;
   logic [7:0]  r_shift;
   logic [7:0]  w_shift_nxt;
   logic [7:0]  r_data;
   logic        r_valid;
   logic        r_ferr;
   logic        r_ovr;
   logic        r_rx_s1;
   logic        r_rx_s2;
   logic        r_ack_s1;
   logic        r_ack_s2;
   logic        r_ack_d;
   logic        w_rx;
   logic        w_ack_edge;
   logic        w_good;
   logic        w_ferr;
   logic        w_unused;

   assign w_unused   = &{1'b0, ena, uio_in, ui_in[7:2]};
   assign w_rx       = r_rx_s2;
   assign w_ack_edge = r_ack_s2 & ~r_ack_d;

   // rx idles high so its synchronizer resets to 1; otherwise reset release looks like a start bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rx_s1  <= 1'b1;
         r_rx_s2  <= 1'b1;
         r_ack_s1 <= 1'b0;
         r_ack_s2 <= 1'b0;
         r_ack_d  <= 1'b0;
      end else begin
         r_rx_s1  <= ui_in[0];
         r_rx_s2  <= r_rx_s1;
         r_ack_s1 <= ui_in[1];
         r_ack_s2 <= r_ack_s1;
         r_ack_d  <= r_ack_s2;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= 16'd0;
         r_bit   <= 3'd0;
         r_shift <= 8'd0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_bit   <= w_bit_nxt;
         r_shift <= w_shift_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt + 16'd1;
      w_bit_nxt   = r_bit;
      w_shift_nxt = r_shift;
      w_good      = 1'b0;
      w_ferr      = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_cnt_nxt = 16'd0;
            if (!w_rx) begin
               w_state_nxt = S_START;
            end
         end
         S_START: begin
            if (r_cnt == HALF_M1) begin
               w_cnt_nxt   = 16'd0;
               w_bit_nxt   = 3'd0;
               w_state_nxt = w_rx ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            if (r_cnt == FULL_M1) begin
               w_cnt_nxt   = 16'd0;
               w_shift_nxt = {w_rx, r_shift[7:1]};
               if (r_bit == 3'd7) begin
                  w_bit_nxt   = 3'd0;
                  w_state_nxt = S_STOP;
               end else begin
                  w_bit_nxt = r_bit + 3'd1;
               end
            end
         end
         S_STOP: begin
            if (r_cnt == FULL_M1) begin
               w_cnt_nxt = 16'd0;
               if (w_rx) begin
                  w_good      = 1'b1;
                  w_state_nxt = S_IDLE;
               end else begin
                  w_ferr      = 1'b1;
                  w_state_nxt = S_WAIT_HIGH;
               end
            end
         end
         S_WAIT_HIGH: begin
            // A held-low line (break) must not be re-taken as a fresh start bit.
            w_cnt_nxt = 16'd0;
            if (w_rx) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_cnt_nxt   = 16'd0;
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // A completion event in the same cycle as an ack wins for its own flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_data  <= 8'd0;
         r_valid <= 1'b0;
         r_ferr  <= 1'b0;
         r_ovr   <= 1'b0;
      end else begin
         if (w_good) begin
            r_data <= r_shift;
         end

         if (w_good) begin
            r_valid <= 1'b1;
         end else if (w_ack_edge) begin
            r_valid <= 1'b0;
         end

         if (w_ferr) begin
            r_ferr <= 1'b1;
         end else if (w_ack_edge) begin
            r_ferr <= 1'b0;
         end

         if (w_ack_edge) begin
            r_ovr <= 1'b0;
         end else if (w_good && r_valid) begin
            r_ovr <= 1'b1;
         end
      end
   end

   assign uo_out  = r_data;
   assign uio_out = {4'b0000, (r_state != S_IDLE), r_ovr, r_ferr, r_valid};
   assign uio_oe  = 8'h0F;

endmodule

// File: tb/tb_tt_um_uart_rx.sv
// Directed bench for tt_um_uart_rx at 16 clocks per bit; inputs driven and outputs sampled on falling edges.
module tb_tt_um_uart_rx;

   logic       clk;
   logic       rst_n;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uo_out;
   logic [7:0] uio_in;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   int n_checks;
   int n_errors;
   int cyc;
   int ack_on;
   int ack_off;

   typedef struct {
      logic [7:0] data;
      logic       stop;
      logic       ack_before;
      logic [7:0] exp_uo;
      logic [7:0] exp_uio;
   } vec_t;

   vec_t vecs[7];

   tt_um_uart_rx #(.CLKS_PER_BIT(16)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .ena    (ena),
      .ui_in  (ui_in),
      .uo_out (uo_out),
      .uio_in (uio_in),
      .uio_out(uio_out),
      .uio_oe (uio_oe)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %02h expected %02h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // One falling edge; the ack pin follows the scheduled window.
   task automatic step();
      @(negedge clk);
      cyc++;
      ui_in[1] = (cyc >= ack_on && cyc < ack_off) ? 1'b1 : 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         step();
         ui_in[0] = 1'b1;
      end
   endtask

   task automatic pulse_ack();
      ack_on  = cyc + 1;
      ack_off = cyc + 6;
      idle(12);
   endtask

   // k counts falling edges from the one that drives the start bit.
   task automatic send_frame(input logic [7:0] d, input logic stop, input int rst_at,
                             input logic [7:0] uo_before, input logic [7:0] exp_uo,
                             input logic [7:0] exp_uio, input string name);
      logic [9:0] bits;
      bits = {stop, d, 1'b0};
      for (int k = 0; k < 160; k++) begin
         step();
         ui_in[0] = bits[k / 16];
         if (rst_at >= 0) begin
            if (k == rst_at) rst_n = 1'b0;
            if (k == rst_at + 2) begin
               chk({name, "_rst_uo"}, uo_out, 8'h00);
               chk({name, "_rst_uio"}, uio_out, 8'h00);
            end
         end else begin
            if (k == 154) begin
               chk({name, "_pre_busy"}, {7'd0, uio_out[3]}, 8'h01);
               chk({name, "_pre_uo"}, uo_out, uo_before);
            end
            if (k == 155) begin
               chk({name, "_uo"}, uo_out, exp_uo);
               chk({name, "_uio"}, uio_out, exp_uio);
            end
         end
      end
   endtask

   initial begin
      int busy_seen;
      logic [7:0] cur_uo;

      vecs[0] = '{8'hC3, 1'b1, 1'b0, 8'hC3, 8'h01};
      vecs[1] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 8'h01};
      vecs[2] = '{8'h00, 1'b1, 1'b0, 8'h00, 8'h05};
      vecs[3] = '{8'h3C, 1'b0, 1'b1, 8'h00, 8'h0A};
      vecs[4] = '{8'h5A, 1'b1, 1'b0, 8'h5A, 8'h03};
      vecs[5] = '{8'h81, 1'b1, 1'b1, 8'h81, 8'h01};
      vecs[6] = '{8'h7E, 1'b0, 1'b0, 8'h81, 8'h0B};

      n_checks = 0;
      n_errors = 0;
      cyc      = 0;
      ack_on   = 0;
      ack_off  = 0;
      ena      = 1'b1;
      uio_in   = 8'h00;
      ui_in    = 8'h01;
      rst_n    = 1'b0;

      // Reset state and idle line
      idle(4);
      chk("reset_uo", uo_out, 8'h00);
      chk("reset_uio", uio_out, 8'h00);
      chk("reset_oe", uio_oe, 8'h0F);
      rst_n = 1'b1;
      busy_seen = 0;
      for (int i = 0; i < 1000; i++) begin
         idle(1);
         if (uio_out[3]) busy_seen++;
      end
      chk("idle_busy_count", 8'(busy_seen), 8'h00);
      chk("idle_oe", uio_oe, 8'h0F);

      // 0xA5 with exact timing, then ack clears valid three cycles after the pin rises
      send_frame(8'hA5, 1'b1, -1, 8'h00, 8'hA5, 8'h01, "a5");
      ack_on  = cyc + 1;
      ack_off = cyc + 25;
      idle(3);
      chk("ack_t2_valid", uio_out, 8'h01);
      idle(1);
      chk("ack_t3_valid", uio_out, 8'h00);
      chk("ack_t3_uo", uo_out, 8'hA5);
      idle(30);
      cur_uo = 8'hA5;

      for (int v = 0; v < 7; v++) begin
         if (vecs[v].ack_before) pulse_ack();
         send_frame(vecs[v].data, vecs[v].stop, -1, cur_uo, vecs[v].exp_uo,
                    vecs[v].exp_uio, $sformatf("vec%0d", v));
         cur_uo = vecs[v].exp_uo;
         idle(20);
         chk($sformatf("vec%0d_idle_busy", v), {7'd0, uio_out[3]}, 8'h00);
      end

      // Glitch: 5 low cycles enter START only, nothing else changes
      for (int k = 0; k < 30; k++) begin
         step();
         ui_in[0] = (k < 5) ? 1'b0 : 1'b1;
         if (k == 8) chk("glitch_busy", {7'd0, uio_out[3]}, 8'h01);
         if (k == 12) chk("glitch_back_idle", {7'd0, uio_out[3]}, 8'h00);
         if (k == 20) begin
            chk("glitch_uio", uio_out, 8'h03);
            chk("glitch_uo", uo_out, 8'h81);
         end
      end

      // Frame error: busy held while the line stays low
      pulse_ack();
      send_frame(8'h3C, 1'b0, -1, 8'h81, 8'h81, 8'h0A, "ferr");
      for (int i = 0; i < 40; i++) begin
         step();
         ui_in[0] = 1'b0;
      end
      chk("ferr_break_busy", uio_out, 8'h0A);
      idle(5);
      chk("ferr_line_high", uio_out, 8'h02);
      pulse_ack();
      chk("ferr_ack", uio_out, 8'h00);

      // Back-to-back frames without ack
      send_frame(8'h11, 1'b1, -1, 8'h81, 8'h11, 8'h01, "ovr_a");
      send_frame(8'h22, 1'b1, -1, 8'h11, 8'h22, 8'h05, "ovr_b");
      idle(10);
      pulse_ack();
      chk("ovr_ack_uio", uio_out, 8'h00);
      chk("ovr_ack_uo", uo_out, 8'h22);

      // Ack edge lands on the second stop-sample edge
      send_frame(8'h33, 1'b1, -1, 8'h22, 8'h33, 8'h01, "coin_a");
      ack_on  = cyc + 1 + 152;
      ack_off = ack_on + 6;
      send_frame(8'h44, 1'b1, -1, 8'h33, 8'h44, 8'h01, "coin_b");
      idle(20);
      chk("coin_after_uio", uio_out, 8'h01);
      pulse_ack();

      // Reset during data bit 4 of 0x5A, held until the frame has left the line
      send_frame(8'h5A, 1'b1, 88, 8'h00, 8'h00, 8'h00, "rst_mid");
      idle(5);
      rst_n = 1'b1;
      idle(20);
      chk("rst_rel_uio", uio_out, 8'h00);
      chk("rst_rel_uo", uo_out, 8'h00);
      send_frame(8'h81, 1'b1, -1, 8'h00, 8'h81, 8'h01, "post_rst");
      idle(10);
      chk("post_rst_final", uio_out, 8'h01);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
